status_readout: RTL and testbench

- Read-back path for the POLI test-structure block; the counterpart to the control register, which receives configuration from the host.
- On a host read request it snapshots the status word of one selected test structure.
- It frames the word with an address echo and a parity bit, then serialises it MSB-first on a single output pin at a programmable bit rate.
- Sits between the test-structure array (parallel status bus) and the chip's serial debug/readout pad.

---
 rtl/status_readout_pkg.sv | 32 +++
 rtl/status_readout_frame_shifter.sv | 65 ++++++
 rtl/status_readout.sv | 124 ++++++++++++
 tb/tb_status_readout.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/status_readout_pkg.sv
// Shared types and helpers for the status read-back path.
package status_readout_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } readout_state_t;

    localparam int unsigned DEF_N_STRUCT = 8;
    localparam int unsigned DEF_ADDR_W   = 3;
    localparam int unsigned DEF_STATUS_W = 8;
    localparam int unsigned DEF_BIT_DIV  = 4;

    // Widest addr+status payload the parity helper accepts; zero padding leaves parity unchanged.
    localparam int unsigned PARITY_MAX_W = 64;

    function automatic int unsigned frame_len(input int unsigned addr_w, input int unsigned status_w);
        return 2 + addr_w + status_w;
    endfunction

    // Divider counter needs at least one bit to exist even when BIT_DIV is 1.
    function automatic int unsigned div_width(input int unsigned bit_div);
        return (bit_div > 1) ? $clog2(bit_div) : 1;
    endfunction

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/status_readout_frame_shifter.sv
// Parallel-load, MSB-first frame shift register; each bit held BIT_DIV cycles.
module status_readout_frame_shifter
    import status_readout_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 13,
    parameter int unsigned BIT_DIV   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load,
    input  logic [FRAME_LEN-1:0] load_data,
    input  logic                 shift_active,
    output logic                 sdo,
    output logic                 last_bit
);

    localparam int unsigned DIV_W = div_width(BIT_DIV);
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_bit_q, last_bit_d;
    logic                 bit_end_c;

    // Zeros are shifted in, so sdo returns to 0 once the whole frame has left.
    always_comb begin
        sr_d      = sr_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_end_c = (div_q == DIV_W'(BIT_DIV - 1));
        if (load) begin
            sr_d  = load_data;
            div_d = '0;
            cnt_d = '0;
        end else if (shift_active) begin
            if (bit_end_c) begin
                div_d = '0;
                sr_d  = {sr_q[FRAME_LEN-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        last_bit_d = (cnt_d == CNT_W'(FRAME_LEN - 1)) && (div_d == DIV_W'(BIT_DIV - 1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q       <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            last_bit_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            last_bit_q <= last_bit_d;
        end
    end

    assign sdo      = sr_q[FRAME_LEN-1];
    assign last_bit = last_bit_q;

endmodule

// File: rtl/status_readout.sv
// Host read-back of one test-structure status word, framed with address echo
// and even parity, serialised MSB-first on a single pin.
module status_readout
    import status_readout_pkg::*;
#(
    parameter int unsigned N_STRUCT = DEF_N_STRUCT,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned STATUS_W = DEF_STATUS_W,
    parameter int unsigned BIT_DIV  = DEF_BIT_DIV
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic [N_STRUCT*STATUS_W-1:0] status_bus,
    output logic                         busy,
    output logic                         sdo,
    output logic                         sdo_valid,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned FRAME_LEN = frame_len(ADDR_W, STATUS_W);

    readout_state_t       state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;

    logic                 addr_bad_c;
    logic                 load_c;
    logic                 shift_last;
    logic [STATUS_W-1:0]  status_sel_c;
    logic [FRAME_LEN-1:0] frame_c;

    // Extra MSB lets N_STRUCT == 2**ADDR_W compare without overflow.
    assign addr_bad_c = ({1'b0, rd_addr} >= (ADDR_W + 1)'(N_STRUCT));

    always_comb begin
        status_sel_c = '0;
        for (int unsigned i = 0; i < N_STRUCT; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                status_sel_c = status_bus[i*STATUS_W +: STATUS_W];
            end
        end
    end

    assign frame_c = {1'b1, addr_q, status_sel_c,
                      even_parity(PARITY_MAX_W'({addr_q, status_sel_c}))};
    assign load_c  = (state_q == CAPTURE);

    // Out-of-range requests skip CAPTURE/SHIFT and report via err.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    addr_d  = rd_addr;
                    err_d   = addr_bad_c;
                    state_d = addr_bad_c ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                err_d   = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (shift_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == SHIFT);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    status_readout_frame_shifter #(
        .FRAME_LEN (FRAME_LEN),
        .BIT_DIV   (BIT_DIV)
    ) u_shifter (
        .CLK          (CLK),
        .RST          (RST),
        .load         (load_c),
        .load_data    (frame_c),
        .shift_active (state_q == SHIFT),
        .sdo          (sdo),
        .last_bit     (shift_last)
    );

    assign busy      = busy_q;
    assign sdo_valid = valid_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_status_readout.sv
// Bench for status_readout: two instances (N_STRUCT=6/BIT_DIV=4 and N_STRUCT=8/BIT_DIV=1)
// checked every cycle against an elapsed-time frame model, plus literal anchors.
module tb_status_readout;

    localparam int L = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        req [2];
    logic [2:0]  addr [2];
    logic [47:0] bus0;
    logic [63:0] bus1;
    logic        o_busy [2];
    logic        o_sdo [2];
    logic        o_valid [2];
    logic        o_done [2];
    logic        o_err [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: elapsed cycles since acceptance (0 = idle) plus the captured frame.
    int          m_t [2];
    logic        m_bad [2];
    logic        m_err [2];
    logic [2:0]  m_addr [2];
    logic [12:0] m_frame [2];

    always #5 clk = ~clk;

    status_readout #(.N_STRUCT(6), .ADDR_W(3), .STATUS_W(8), .BIT_DIV(4)) dut0 (
        .CLK(clk), .RST(rst), .rd_req(req[0]), .rd_addr(addr[0]), .status_bus(bus0),
        .busy(o_busy[0]), .sdo(o_sdo[0]), .sdo_valid(o_valid[0]), .done(o_done[0]), .err(o_err[0])
    );

    status_readout #(.N_STRUCT(8), .ADDR_W(3), .STATUS_W(8), .BIT_DIV(1)) dut1 (
        .CLK(clk), .RST(rst), .rd_req(req[1]), .rd_addr(addr[1]), .status_bus(bus1),
        .busy(o_busy[1]), .sdo(o_sdo[1]), .sdo_valid(o_valid[1]), .done(o_done[1]), .err(o_err[1])
    );

    function automatic int n_of(input int k);
        return (k == 0) ? 6 : 8;
    endfunction

    function automatic int d_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] status_of(input int k, input logic [2:0] a);
        int base;
        base = int'(a) * 8;
        if (k == 0) return bus0[base +: 8];
        return bus1[base +: 8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_t[k]   = 0;
                m_err[k] = 1'b0;
                m_bad[k] = 1'b0;
            end else if (m_t[k] == 0) begin
                if (req[k]) begin
                    m_addr[k] = addr[k];
                    m_bad[k]  = (int'(addr[k]) >= n_of(k));
                    m_err[k]  = m_bad[k];
                    m_t[k]    = 1;
                end
            end else begin
                if (m_t[k] == 1 && !m_bad[k]) begin
                    logic [7:0] s;
                    s = status_of(k, m_addr[k]);
                    m_frame[k] = {1'b1, m_addr[k], s, 1'(($countones({m_addr[k], s}) % 2) == 1)};
                end
                m_t[k]++;
                if (m_bad[k] ? (m_t[k] > 1) : (m_t[k] > 2 + L * d_of(k))) m_t[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic v_e, s_e, d_e;
                v_e = !m_bad[k] && m_t[k] >= 2 && m_t[k] <= 1 + L * d_of(k);
                s_e = v_e ? m_frame[k][L - 1 - (m_t[k] - 2) / d_of(k)] : 1'b0;
                d_e = m_bad[k] ? (m_t[k] == 1) : (m_t[k] == 2 + L * d_of(k));
                chk($sformatf("dut%0d busy", k), 32'(o_busy[k]), 32'(m_t[k] != 0));
                chk($sformatf("dut%0d sdo_valid", k), 32'(o_valid[k]), 32'(v_e));
                chk($sformatf("dut%0d sdo", k), 32'(o_sdo[k]), 32'(s_e));
                chk($sformatf("dut%0d done", k), 32'(o_done[k]), 32'(d_e));
                chk($sformatf("dut%0d err", k), 32'(o_err[k]), 32'(m_err[k]));
            end
        end
    end

    task automatic run0(input logic [2:0] a, input int ncyc,
                        output int done_at, output logic err1, output int vcnt);
        done_at = -1;
        vcnt    = 0;
        err1    = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (o_done[0] && done_at < 0) done_at = c;
            if (o_valid[0]) vcnt++;
            if (c == 1) err1 = o_err[0];
            req[0]  = (c == 0);
            addr[0] = a;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [12:0] exp0, exp1;
        int vcnt0, dcnt0, dcyc0, dcyc1, d, v, dn [$];
        logic e;

        rst     = 1'b1;
        req[0]  = 1'b0;
        req[1]  = 1'b0;
        addr[0] = '0;
        addr[1] = '0;
        bus0    = 48'({$urandom(), $urandom()});
        bus1    = {$urandom(), $urandom()};
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", 32'(o_busy[0]), 0);
        chk("reset sdo_valid", 32'(o_valid[0]), 0);
        chk("reset err", 32'(o_err[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Addr 5 / 0xA5 on dut0 with snapshot and ignored-request checks; addr 0 / 0xFF on dut1.
        exp0 = 13'b1101101001010;
        exp1 = 13'b1000111111110;
        bus0[40 +: 8] = 8'hA5;
        bus1[0 +: 8]  = 8'hFF;
        vcnt0 = 0; dcnt0 = 0; dcyc0 = -1; dcyc1 = -1;
        for (int c = 0; c < 60; c++) begin
            if (o_valid[0]) vcnt0++;
            if (o_done[0]) begin dcnt0++; dcyc0 = c; end
            if (o_done[1] && dcyc1 < 0) dcyc1 = c;
            if (c == 1) chk("A busy cycle1", 32'(o_busy[0]), 1);
            if (c == 2) begin
                chk("model pin A", 32'(m_frame[0]), 32'(exp0));
                chk("model pin F", 32'(m_frame[1]), 32'(exp1));
            end
            if (c >= 2 && c < 54 && (c - 2) % 4 == 1) chk("A frame bit", 32'(o_sdo[0]), 32'(exp0[12 - (c - 2) / 4]));
            if (c >= 2 && c < 15) chk("F frame bit", 32'(o_sdo[1]), 32'(exp1[14 - c]));
            req[0]  = (c == 0 || c == 5 || c == 30);
            addr[0] = (c == 0) ? 3'd5 : 3'd2;
            req[1]  = (c == 0);
            addr[1] = 3'd0;
            if (c == 10) bus0[40 +: 8] = 8'h00;
            @(negedge clk);
        end
        chk("A valid cycles", 32'(vcnt0), 52);
        chk("A done cycle", 32'(dcyc0), 54);
        chk("A done count", 32'(dcnt0), 1);
        chk("A err", 32'(o_err[0]), 0);
        chk("F done cycle", 32'(dcyc1), 15);

        // Out-of-range addresses, then a valid read clearing err in CAPTURE.
        run0(3'd7, 4, d, e, v);
        chk("bad7 done cycle", 32'(d), 1);
        chk("bad7 err", 32'(e), 1);
        chk("bad7 valid cycles", 32'(v), 0);
        chk("bad7 err held", 32'(o_err[0]), 1);
        run0(3'd6, 4, d, e, v);
        chk("bad6 done cycle", 32'(d), 1);
        chk("bad6 err", 32'(e), 1);
        run0(3'd0, 60, d, e, v);
        chk("ok0 err in capture", 32'(e), 0);
        chk("ok0 done cycle", 32'(d), 54);
        chk("ok0 valid cycles", 32'(v), 52);

        // Reset mid-frame, then a fresh request.
        dcnt0 = 0; dcyc0 = -1;
        for (int c = 0; c < 85; c++) begin
            if (o_done[0]) begin dcnt0++; dcyc0 = c; end
            if (c == 21) begin
                chk("rst busy", 32'(o_busy[0]), 0);
                chk("rst sdo_valid", 32'(o_valid[0]), 0);
                chk("rst sdo", 32'(o_sdo[0]), 0);
            end
            if (c == 23) chk("rst no done", 32'(dcnt0), 0);
            rst     = (c == 20);
            req[0]  = (c == 0 || c == 23);
            addr[0] = (c == 0) ? 3'd3 : 3'd4;
            @(negedge clk);
        end
        chk("post-rst done cycle", 32'(dcyc0), 77);

        // rd_req held high: second request starts after one IDLE cycle.
        dn.delete();
        for (int c = 0; c < 115; c++) begin
            if (o_done[0]) dn.push_back(c);
            if (c == 55) chk("b2b idle gap", 32'(o_busy[0]), 0);
            req[0]  = (c < 110);
            addr[0] = 3'd1;
            @(negedge clk);
        end
        chk("b2b done count", 32'(dn.size()), 2);
        if (dn.size() == 2) begin
            chk("b2b done1", 32'(dn[0]), 54);
            chk("b2b done2", 32'(dn[1]), 109);
        end

        // Randomized traffic with occasional resets and status churn.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                req[k]  = ($urandom_range(0, 3) == 0);
                addr[k] = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 7) == 0) bus0 = 48'({$urandom(), $urandom()});
            if ($urandom_range(0, 7) == 0) bus1 = {$urandom(), $urandom()};
            @(negedge clk);
        end
        rst = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (60) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
